// File: rtl/bcd4_counter_fnd.sv
// bcd4_counter_fnd
//   Four-digit BCD up/down counter advanced by rising edges of the divided
//   clock. The divided clock is sampled as data in the mclk domain. The four
//   digits are time-multiplexed onto a common-anode 7-segment display.
//
// Ports
//   mclk     system clock, all state on rising edge
//   rst      asynchronous active-high reset
//   clk_div  divided clock from the divider stage (asynchronous data)
//   run      1 = count on ticks, 0 = hold (ticks are dropped)
//   clear    synchronous clear of the count, highest priority
//   up_dn    1 = count up, 0 = count down
//   bcd      {d3,d2,d1,d0}, registered
//   wrap     one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
//   fnd_com  active-low digit enables, bit i drives digit i
//   fnd_seg  active-low segments {dp,g,f,e,d,c,b,a}, dp always off
module bcd4_counter_fnd #(
  parameter int SCAN_DIV = 1000,
  parameter int SCAN_W   = 10
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        clk_div,
  input  logic        run,
  input  logic        clear,
  input  logic        up_dn,
  output logic [15:0] bcd,
  output logic        wrap,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_seg
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              s1, s2, s3;
  logic              tick;
  logic [15:0]       bcd_nxt;
  logic              wrap_nxt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig_sel;
  logic [3:0]        dig_cur;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  // s1/s2 resynchronise clk_div; s3 is only a delay for edge detection.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_div;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Ripple carry/borrow through the digits; whatever remains after d3
  // means the whole counter rolled over.
  always_comb begin
    logic       cy;
    logic [3:0] d;
    bcd_nxt  = bcd;
    wrap_nxt = 1'b0;
    cy       = 1'b1;
    d        = 4'd0;
    if (clear) begin
      bcd_nxt = 16'h0000;
    end else if (run && tick) begin
      for (int i = 0; i < 4; i++) begin
        d = bcd[4*i +: 4];
        if (cy) begin
          if (up_dn) begin
            if (d >= 4'd9) begin
              d  = 4'd0;
            end else begin
              d  = d + 4'd1;
              cy = 1'b0;
            end
          end else begin
            if (d == 4'd0) begin
              d  = 4'd9;
            end else begin
              d  = d - 4'd1;
              cy = 1'b0;
            end
          end
        end
        bcd_nxt[4*i +: 4] = d;
      end
      wrap_nxt = cy;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      bcd  <= 16'h0000;
      wrap <= 1'b0;
    end else begin
      bcd  <= bcd_nxt;
      wrap <= wrap_nxt;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_sel  <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_sel  <= dig_sel + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    dig_cur = bcd[3:0];
    case (dig_sel)
      2'd0: dig_cur = bcd[3:0];
      2'd1: dig_cur = bcd[7:4];
      2'd2: dig_cur = bcd[11:8];
      2'd3: dig_cur = bcd[15:12];
      default: dig_cur = bcd[3:0];
    endcase
  end

  // Enable and glyph come from the same select in the same register stage,
  // so a glyph is never shown on a neighbouring digit.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      fnd_com <= 4'b1110;
      fnd_seg <= 8'hC0;
    end else begin
      fnd_com <= ~(4'b0001 << dig_sel);
      fnd_seg <= seg_decode(dig_cur);
    end
  end

endmodule

// File: tb/tb_bcd4_counter_fnd.sv
module tb_bcd4_counter_fnd;

  logic        mclk = 1'b0;
  logic        rst;
  logic        clk_div;
  logic        run;
  logic        clear;
  logic        up_dn;
  logic [15:0] bcd;
  logic        wrap;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_seg;

  int n_cmp = 0;
  int n_bad = 0;

  bcd4_counter_fnd #(.SCAN_DIV(4), .SCAN_W(3)) dut (
    .mclk    (mclk),
    .rst     (rst),
    .clk_div (clk_div),
    .run     (run),
    .clear   (clear),
    .up_dn   (up_dn),
    .bcd     (bcd),
    .wrap    (wrap),
    .fnd_com (fnd_com),
    .fnd_seg (fnd_seg)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clk_div pulse raised just before edge N. Samples #1 after edges
  // N..N+3; reports which edge changed bcd (-1 = none) and wrap-high count.
  task automatic div_pulse(output int chg_at, output int wrap_cyc);
    logic [15:0] prev;
    @(negedge mclk);
    prev     = bcd;
    chg_at   = -1;
    wrap_cyc = 0;
    clk_div  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge mclk); #1;
      if (k == 1) clk_div = 1'b0;
      if (wrap) wrap_cyc++;
      if (bcd !== prev && chg_at < 0) chg_at = k;
      prev = bcd;
    end
  endtask

  task automatic ticks(input int n);
    int c, w;
    for (int i = 0; i < n; i++) div_pulse(c, w);
  endtask

  initial begin
    int c, w, chg;
    int waited;
    logic [3:0] exp_com [4];
    logic [7:0] exp_seg [4];
    exp_com = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    rst = 1'b1; clk_div = 1'b0; run = 1'b1; clear = 1'b0; up_dn = 1'b1;
    repeat (3) @(negedge mclk);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
    chk("rst_com", {12'd0, fnd_com}, 16'h000E);
    chk("rst_seg", {8'd0, fnd_seg}, 16'h00C0);
    rst = 1'b0;
    repeat (2) @(negedge mclk);

    // first tick: latency exactly 2 edges after s1 capture
    div_pulse(c, w);
    chk("lat_edge", 16'(c), 16'd2);
    chk("up_first", bcd, 16'h0001);
    ticks(11);
    chk("up_12", bcd, 16'h0012);

    // held-high clk_div gives a single step
    @(negedge mclk);
    clk_div = 1'b1;
    chg = 0;
    for (int k = 0; k < 20; k++) begin
      logic [15:0] p;
      p = bcd;
      @(posedge mclk); #1;
      if (bcd !== p) chg++;
    end
    clk_div = 1'b0;
    repeat (3) @(negedge mclk);
    chk("hold_hi_steps", 16'(chg), 16'd1);
    chk("hold_hi_bcd", bcd, 16'h0013);

    ticks(87);
    chk("up_100", bcd, 16'h0100);
    up_dn = 1'b0;
    div_pulse(c, w);
    chk("dn_borrow", bcd, 16'h0099);
    chk("dn_borrow_wrap", 16'(w), 16'd0);

    @(negedge mclk); clear = 1'b1;
    @(negedge mclk); clear = 1'b0;
    chk("clear_only", bcd, 16'h0000);

    div_pulse(c, w);
    chk("dn_wrap_bcd", bcd, 16'h9999);
    chk("dn_wrap_cyc", 16'(w), 16'd1);
    up_dn = 1'b1;
    div_pulse(c, w);
    chk("up_wrap_bcd", bcd, 16'h0000);
    chk("up_wrap_cyc", 16'(w), 16'd1);
    div_pulse(c, w);
    chk("post_wrap_bcd", bcd, 16'h0001);
    chk("post_wrap_cyc", 16'(w), 16'd0);

    // clear in the very cycle tick is high
    ticks(49);
    chk("at_50", bcd, 16'h0050);
    @(negedge mclk); clk_div = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    @(posedge mclk);
    @(negedge mclk); clear = 1'b1;
    @(posedge mclk); #1;
    chk("clr_vs_tick", bcd, 16'h0000);
    chk("clr_vs_tick_wrap", {15'd0, wrap}, 16'd0);
    @(negedge mclk); clear = 1'b0; clk_div = 1'b0;
    repeat (3) @(negedge mclk);
    chk("clr_no_late", bcd, 16'h0000);

    run = 1'b0;
    ticks(5);
    chk("run0_hold", bcd, 16'h0000);
    run = 1'b1;
    ticks(1);
    chk("run1_one", bcd, 16'h0001);

    ticks(1233);
    chk("at_1234", bcd, 16'h1234);

    // align to the first cycle digit 0 is lit after digit 3
    waited = 0;
    while (fnd_com !== 4'b0111 && waited < 40) begin @(negedge mclk); waited++; end
    while (fnd_com !== 4'b1110 && waited < 40) begin @(negedge mclk); waited++; end
    if (waited >= 40) chk("scan_align_timeout", 16'(waited), 16'd0);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("scan_com_d%0d_c%0d", d, k), {12'd0, fnd_com}, {12'd0, exp_com[d]});
        chk($sformatf("scan_seg_d%0d_c%0d", d, k), {8'd0, fnd_seg}, {8'd0, exp_seg[d]});
        @(negedge mclk);
      end
    end
    chk("scan_period", {12'd0, fnd_com}, 16'h000E);

    // reset mid-count, effective without a clock edge
    @(negedge mclk); clear = 1'b1;
    @(negedge mclk); clear = 1'b0;
    ticks(457);
    chk("at_457", bcd, 16'h0457);
    @(posedge mclk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bcd", bcd, 16'h0000);
    chk("async_rst_wrap", {15'd0, wrap}, 16'd0);
    chk("async_rst_com", {12'd0, fnd_com}, 16'h000E);
    chk("async_rst_seg", {8'd0, fnd_seg}, 16'h00C0);
    @(negedge mclk); rst = 1'b0;
    ticks(1);
    chk("after_rst_tick", bcd, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
